proc_reg_file_multi: RTL and testbench
======================================

// Module: proc_reg_file_multi
// PURPOSE
//  Per-thread process (pointer) register file: THREADS contexts x REGS registers x WIDTH bits.
//  Generalises the fixed 32-thread/2-reg/12-bit file: two async read ports, one write port,
//  and a post-inc/dec port for pointer stepping. Adds a per-thread clear engine and a reset init sweep.
//  Sits beside the thread scheduler; the decode stage reads it, and the execute stage writes or steps it.
// PARAMETERS
//  THREADS    32   number of thread contexts (power of 2); TW = $clog2(THREADS)
//  REGS       4    registers per thread (power of 2, >=2); RW = $clog2(REGS)
//  WIDTH      12   register width in bits
//  RESET_VAL  0    value loaded by the reset sweep and by a thread clear
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  rthreadid  in   TW     thread selected for both read ports
//  psel0      in   RW     register select, read port 0
//  psel1      in   RW     register select, read port 1
//  qp0        out  WIDTH  read data 0; combinational from the array
//  qp1        out  WIDTH  read data 1; combinational from the array
//  wthreadid  in   TW     write thread
//  pselw      in   RW     write register
//  d          in   WIDTH  write data
//  wep        in   1      write enable
//  ithreadid  in   TW     step thread
//  pseli      in   RW     step register
//  inc        in   1      step enable
//  dec        in   1      step direction: 0 = +1, 1 = -1
//  clr_req    in   1      clear request for clr_tid (sampled only while ready=1)
//  clr_tid    in   TW     thread to clear
//  ready      out  1      1 = idle, so a clear may be accepted
//  clr_done   out  1      1-cycle pulse after the last register of a clear is written
//  ovf        out  1      1-cycle pulse, the cycle after a step that wrapped
//  err        out  1      1-cycle pulse, the cycle after a dropped wep/inc
// BEHAVIOUR
//  Reset: rst=1 forces state INIT and index 0. ready, clr_done, ovf and err are all 0.
//   - INIT writes RESET_VAL to one entry per cycle, in order thread-major and reg-minor.
//   - The sweep takes THREADS*REGS cycles; then the block goes to IDLE and ready=1.
//   - wep/inc are ignored during INIT and do not raise err.
//  Reads: qp0/qp1 show the array contents. A write at posedge N is visible on the reads after posedge N.
//   - There is no bypass of same-cycle write data.
//  Write: wep=1 stores d into [wthreadid][pselw] at posedge.
//  Step: inc=1 stores [ithreadid][pseli] + 1 (dec=0) or - 1 (dec=1), arithmetic mod 2^WIDTH.
//   - ovf pulses the next cycle if the step wrapped: all-ones to 0, or 0 to all-ones.
//  Collision: if wep and inc hit the same entry in the same cycle, the write wins.
//   - The step is discarded and no ovf is raised. Different entries both update.
//  FSM states:
//   - IDLE: on clr_req=1, latch clr_tid, set idx=0, ready=0, go to CLEAR.
//   - CLEAR: write RESET_VAL to [tid][idx] and increment idx. At idx=REGS-1, go to IDLE and pulse clr_done.
//   - A clear therefore lasts REGS cycles; ready returns to 1 in the same cycle clr_done pulses.
//  During CLEAR:
//   - wep/inc targeting the clearing thread are dropped and err pulses the next cycle.
//   - Writes and steps to other threads proceed normally.
//   - clr_req is ignored while ready=0; it is not queued.
//  rst during CLEAR aborts the clear with no clr_done and restarts the INIT sweep.
// TESTING
//  1. rst 1 cycle, then wait THREADS*REGS cycles -> ready=1; every [t][r] reads RESET_VAL=0.
//  2. For all t, r: write 0xAAA, then 0x555, then (t<<r)&0xFFF -> each reads back the cycle after.
//     Then re-read all via both ports -> t<<r on qp0 and qp1.
//  3. Set [3][1]=0xFFF, inc dec=0 -> reads 0x000 and ovf=1. Then inc dec=1 -> reads 0xFFF and ovf=1.
//  4. Same cycle: wep d=0x123 and inc on [5][2] -> reads 0x123, ovf=0.
//     wep on [5][2] and inc on [5][3] -> both update.
//  5. Fill thread 7 with 0x7A, clr_req tid=7 -> ready=0 for 4 cycles, clr_done pulses.
//     Thread 7 reads 0 and thread 8 is unchanged.
//     A wep to [7][0] mid-clear -> dropped, err=1. A wep to [9][0] mid-clear -> stored.
//  6. rst asserted 2 cycles into a clear -> no clr_done; INIT re-runs and all entries read RESET_VAL.

Source files
------------

// File: rtl/proc_reg_file_multi.sv
// Per-thread pointer register file: two async reads, one write, one step port.
// Includes a reset init sweep and a per-thread clear engine.
module proc_reg_file_multi #(
  parameter int THREADS = 32,
  parameter int REGS = 4,
  parameter int WIDTH = 12,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int TW = $clog2(THREADS),
  localparam int RW = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    rthreadid,
  input  logic [RW-1:0]    psel0,
  input  logic [RW-1:0]    psel1,
  output logic [WIDTH-1:0] qp0,
  output logic [WIDTH-1:0] qp1,
  input  logic [TW-1:0]    wthreadid,
  input  logic [RW-1:0]    pselw,
  input  logic [WIDTH-1:0] d,
  input  logic             wep,
  input  logic [TW-1:0]    ithreadid,
  input  logic [RW-1:0]    pseli,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_req,
  input  logic [TW-1:0]    clr_tid,
  output logic             ready,
  output logic             clr_done,
  output logic             ovf,
  output logic             err
);

  localparam int AW = TW + RW;
  localparam int N = THREADS * REGS;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic [TW-1:0]    tid_q;
  logic             ready_q;
  logic             clr_done_q;
  logic             ovf_q;
  logic             err_q;
  logic [WIDTH-1:0] mem_q [N];

  logic [AW-1:0]    waddr;
  logic [AW-1:0]    iaddr;
  logic [AW-1:0]    saddr;
  logic             in_init;
  logic             in_clear;
  logic             w_hit;
  logic             i_hit;
  logic             wr_en;
  logic             st_en;
  logic             sw_en;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] step_d;
  logic             wrap;

  assign waddr = {wthreadid, pselw};
  assign iaddr = {ithreadid, pseli};
  assign in_init = (state_q == INIT);
  assign in_clear = (state_q == CLEAR);
  assign w_hit = in_clear && (wthreadid == tid_q);
  assign i_hit = in_clear && (ithreadid == tid_q);

  // the write port beats the step port on a shared entry
  assign wr_en = !rst && wep && !in_init && !w_hit;
  assign st_en = !rst && inc && !in_init && !i_hit
              && !(wr_en && (waddr == iaddr));

  assign sw_en = !rst && (in_init || in_clear);
  assign saddr = in_init ? idx_q : {tid_q, idx_q[RW-1:0]};

  assign cur = mem_q[iaddr];
  assign step_d = dec ? cur - WIDTH'(1) : cur + WIDTH'(1);
  assign wrap = dec ? (cur == '0) : (cur == '1);

  assign qp0 = mem_q[{rthreadid, psel0}];
  assign qp1 = mem_q[{rthreadid, psel1}];

  assign ready = ready_q;
  assign clr_done = clr_done_q;
  assign ovf = ovf_q;
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (st_en) mem_q[iaddr] <= step_d;
    if (wr_en) mem_q[waddr] <= d;
    if (sw_en) mem_q[saddr] <= RESET_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      idx_q      <= '0;
      tid_q      <= '0;
      ready_q    <= 1'b0;
      clr_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      ovf_q      <= st_en && wrap;
      err_q      <= (wep && w_hit) || (inc && i_hit);
      unique case (state_q)
        INIT: begin
          if (idx_q == '1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        IDLE: begin
          if (clr_req) begin
            tid_q   <= clr_tid;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (idx_q[RW-1:0] == '1) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            clr_done_q <= 1'b1;
            idx_q      <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_reg_file_multi.sv
// Directed bench for proc_reg_file_multi with a write/step scoreboard.
// Reference contents are kept in a plain array mirror of the register file.
module tb_proc_reg_file_multi;

  localparam int THREADS = 32;
  localparam int REGS = 4;
  localparam int WIDTH = 12;
  localparam int TW = 5;
  localparam int RW = 2;
  localparam int N = THREADS * REGS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [TW-1:0]    rthreadid = '0;
  logic [RW-1:0]    psel0 = '0;
  logic [RW-1:0]    psel1 = '0;
  logic [WIDTH-1:0] qp0;
  logic [WIDTH-1:0] qp1;
  logic [TW-1:0]    wthreadid = '0;
  logic [RW-1:0]    pselw = '0;
  logic [WIDTH-1:0] d = '0;
  logic             wep = 1'b0;
  logic [TW-1:0]    ithreadid = '0;
  logic [RW-1:0]    pseli = '0;
  logic             inc = 1'b0;
  logic             dec = 1'b0;
  logic             clr_req = 1'b0;
  logic [TW-1:0]    clr_tid = '0;
  logic             ready;
  logic             clr_done;
  logic             ovf;
  logic             err;

  proc_reg_file_multi #(
    .THREADS(THREADS),
    .REGS(REGS),
    .WIDTH(WIDTH),
    .RESET_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rthreadid(rthreadid),
    .psel0(psel0),
    .psel1(psel1),
    .qp0(qp0),
    .qp1(qp1),
    .wthreadid(wthreadid),
    .pselw(pselw),
    .d(d),
    .wep(wep),
    .ithreadid(ithreadid),
    .pseli(pseli),
    .inc(inc),
    .dec(dec),
    .clr_req(clr_req),
    .clr_tid(clr_tid),
    .ready(ready),
    .clr_done(clr_done),
    .ovf(ovf),
    .err(err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  logic [WIDTH-1:0] sbq[$];
  logic [WIDTH-1:0] model[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [WIDTH-1:0] obs);
    if (sbq.size() == 0) begin
      vecs++;
      miss++;
      $error("FAIL %s: scoreboard empty, got %h", tag, obs);
    end else begin
      chk(tag, obs, sbq.pop_front());
    end
  endtask

  task automatic wr(input int t, input int r, input logic [WIDTH-1:0] v);
    wthreadid = TW'(t);
    pselw = RW'(r);
    d = v;
    wep = 1'b1;
    rthreadid = TW'(t);
    psel0 = RW'(r);
    sbq.push_back(v);
    model[t*REGS+r] = v;
    tick();
    wep = 1'b0;
    sb_chk("wr", qp0);
  endtask

  task automatic step(input int t, input int r, input logic dn,
                      input logic exp_ovf);
    logic [WIDTH-1:0] nv;
    nv = dn ? model[t*REGS+r] - 12'd1 : model[t*REGS+r] + 12'd1;
    model[t*REGS+r] = nv;
    sbq.push_back(nv);
    ithreadid = TW'(t);
    pseli = RW'(r);
    dec = dn;
    inc = 1'b1;
    rthreadid = TW'(t);
    psel0 = RW'(r);
    tick();
    inc = 1'b0;
    sb_chk("step", qp0);
    chkb("step_ovf", ovf, exp_ovf);
  endtask

  task automatic read_all(input string tag);
    for (int t = 0; t < THREADS; t++) begin
      for (int r = 0; r < REGS; r++) begin
        rthreadid = TW'(t);
        psel0 = RW'(r);
        psel1 = RW'(r);
        #1;
        chk(tag, qp0, model[t*REGS+r]);
        chk(tag, qp1, model[t*REGS+r]);
      end
    end
  endtask

  initial begin
    int cnt;
    logic seen_done;

    // 1: reset and init sweep
    rst = 1'b1;
    tick();
    chkb("rst_ready", ready, 1'b0);
    chkb("rst_done", clr_done, 1'b0);
    chkb("rst_ovf", ovf, 1'b0);
    chkb("rst_err", err, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < N - 1; i++) tick();
    chkb("init_busy", ready, 1'b0);
    tick();
    chkb("init_ready", ready, 1'b1);
    for (int i = 0; i < N; i++) model[i] = '0;
    read_all("init_rd");

    // 2: write patterns to every entry
    for (int t = 0; t < THREADS; t++) begin
      for (int r = 0; r < REGS; r++) begin
        wr(t, r, 12'hAAA);
        wr(t, r, 12'h555);
        wr(t, r, WIDTH'(t << r));
      end
    end
    read_all("pat_rd");

    // 3: wrapping and plain steps
    wr(3, 1, 12'hFFF);
    step(3, 1, 1'b0, 1'b1);
    step(3, 1, 1'b1, 1'b1);
    step(3, 1, 1'b1, 1'b0);
    tick();
    chkb("ovf_clear", ovf, 1'b0);

    // 4: write/step collisions
    wr(5, 2, 12'hFFF);
    wthreadid = 5'd5;
    pselw = 2'd2;
    d = 12'h123;
    wep = 1'b1;
    ithreadid = 5'd5;
    pseli = 2'd2;
    dec = 1'b0;
    inc = 1'b1;
    sbq.push_back(12'h123);
    model[5*REGS+2] = 12'h123;
    rthreadid = 5'd5;
    psel0 = 2'd2;
    tick();
    wep = 1'b0;
    inc = 1'b0;
    sb_chk("coll_same", qp0);
    chkb("coll_ovf", ovf, 1'b0);

    d = 12'h200;
    wep = 1'b1;
    pseli = 2'd3;
    inc = 1'b1;
    sbq.push_back(12'h200);
    sbq.push_back(12'h029);
    model[5*REGS+2] = 12'h200;
    model[5*REGS+3] = 12'h029;
    psel1 = 2'd3;
    tick();
    wep = 1'b0;
    inc = 1'b0;
    sb_chk("coll_diff_w", qp0);
    sb_chk("coll_diff_i", qp1);

    // 5: clear of thread 7
    for (int r = 0; r < REGS; r++) wr(7, r, 12'h07A);
    clr_tid = 5'd7;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chkb("clr_acc_ready", ready, 1'b0);
    wthreadid = 5'd9;
    pselw = 2'd0;
    d = 12'h999;
    wep = 1'b1;
    model[9*REGS] = 12'h999;
    tick();
    chkb("clr_c0_ready", ready, 1'b0);
    chkb("clr_c0_err", err, 1'b0);
    wthreadid = 5'd7;
    d = 12'h111;
    tick();
    wep = 1'b0;
    chkb("clr_c1_ready", ready, 1'b0);
    chkb("clr_c1_err", err, 1'b1);
    clr_tid = 5'd8;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chkb("clr_c2_ready", ready, 1'b0);
    chkb("clr_c2_done", clr_done, 1'b0);
    chkb("clr_c2_err", err, 1'b0);
    tick();
    chkb("clr_c3_ready", ready, 1'b1);
    chkb("clr_c3_done", clr_done, 1'b1);
    tick();
    chkb("clr_post_done", clr_done, 1'b0);
    chkb("clr_no_queue", ready, 1'b1);
    for (int r = 0; r < REGS; r++) model[7*REGS+r] = '0;
    read_all("clr_rd");

    // 6: reset aborts a clear in progress
    clr_tid = 5'd10;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("abort_ready", ready, 1'b0);
    chkb("abort_done", clr_done, 1'b0);
    cnt = 0;
    seen_done = 1'b0;
    while (!ready && cnt < N + 8) begin
      tick();
      cnt++;
      if (clr_done) seen_done = 1'b1;
    end
    chkb("abort_no_done", seen_done, 1'b0);
    chkb("reinit_ready", ready, 1'b1);
    chk("reinit_cycles", WIDTH'(cnt), WIDTH'(N));
    for (int i = 0; i < N; i++) model[i] = '0;
    read_all("reinit_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
